// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: column scan on a divided tick, row debounce on
// press and release, and a single-entry event register with an overrun flag.
module keypad_scan_ctrl #(
  parameter int CLK_DIV        = 50000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       res,
  input  logic [3:0] row_in,
  input  logic       key_ack,
  input  logic       ovr_clr,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       overrun,
  output logic [1:0] dbg_state
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  // Count value at which one more matching tick completes the debounce.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col_idx, col_nxt;
  logic [3:0]       row_pat, pat_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tick;
  logic             row_single;
  logic [1:0]       row_idx;
  logic             publish;
  logic [3:0]       pub_code;

  assign tick      = (div_cnt == DIV_LAST);
  assign col_out   = ~(4'b0001 << col_idx);
  assign dbg_state = state;

  // Exactly one low row is a key; idle and multi-key patterns are both "no key".
  always_comb begin
    row_single = 1'b1;
    row_idx    = 2'd0;
    case (row_in)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_single = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = col_idx;
    pat_nxt   = row_pat;
    cnt_nxt   = cnt;
    publish   = 1'b0;
    pub_code  = {col_idx, row_idx};
    if (tick) begin
      case (state)
        S_SCAN: begin
          if (row_single) begin
            pat_nxt = row_in;
            cnt_nxt = CNT_W'(1);
            if (DEBOUNCE_TICKS == 1) begin
              publish   = 1'b1;
              cnt_nxt   = '0;
              state_nxt = S_PRESSED;
            end else begin
              state_nxt = S_DEBOUNCE;
            end
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end
        S_DEBOUNCE: begin
          if (row_in == row_pat) begin
            if (cnt == CNT_LAST) begin
              publish   = 1'b1;
              cnt_nxt   = '0;
              state_nxt = S_PRESSED;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else begin
            cnt_nxt   = '0;
            col_nxt   = col_idx + 2'd1;
            state_nxt = S_SCAN;
          end
        end
        S_PRESSED: begin
          if (row_in == 4'hF) begin
            if (DEBOUNCE_TICKS == 1) begin
              cnt_nxt   = '0;
              col_nxt   = col_idx + 2'd1;
              state_nxt = S_SCAN;
            end else begin
              cnt_nxt   = CNT_W'(1);
              state_nxt = S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          if (row_in == 4'hF) begin
            if (cnt == CNT_LAST) begin
              cnt_nxt   = '0;
              col_nxt   = col_idx + 2'd1;
              state_nxt = S_SCAN;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else begin
            cnt_nxt   = '0;
            state_nxt = S_PRESSED;
          end
        end
        default: state_nxt = S_SCAN;
      endcase
    end
  end

  // key_valid/key_ack: an event stays offered until key_ack is seen with
  // key_valid high; key_ack while key_valid is low has no effect.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      div_cnt   <= '0;
      state     <= S_SCAN;
      col_idx   <= 2'd0;
      row_pat   <= 4'hF;
      cnt       <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      state   <= state_nxt;
      col_idx <= col_nxt;
      row_pat <= pat_nxt;
      cnt     <= cnt_nxt;
      if (publish && (!key_valid || key_ack)) begin
        key_valid <= 1'b1;
        key_code  <= pub_code;
      end else if (key_valid && key_ack) begin
        key_valid <= 1'b0;
      end
      if (publish && key_valid && !key_ack) overrun <= 1'b1;
      else if (ovr_clr)                     overrun <= 1'b0;
    end
  end

endmodule
